// File: rtl/ctrl_seq_pkg.sv
// Shared encodings for the ARM-subset control sequencer: state codes,
// sequencer ALU operations and datapath select values.
`timescale 1ns/1ps
package ctrl_seq_pkg;

  typedef enum logic [3:0] {
    S_RST     = 4'd0,
    S_FETCH0  = 4'd1,
    S_FETCH1  = 4'd2,
    S_FETCH2  = 4'd3,
    S_DECODE  = 4'd4,
    S_DP      = 4'd5,
    S_LS_ADDR = 4'd6,
    S_LS_MEM  = 4'd7,
    S_LDR_WB  = 4'd8,
    S_BR_LINK = 4'd9,
    S_BR      = 4'd10
  } state_e;

  localparam logic [4:0] OP_SUB    = 5'd2;
  localparam logic [4:0] OP_ADD    = 5'd4;
  localparam logic [4:0] OP_PASS_B = 5'd13;
  localparam logic [4:0] OP_PASS_A = 5'd16;

  localparam logic [1:0] MA_RN    = 2'd0;
  localparam logic [1:0] MA_RD_PX = 2'd1;
  localparam logic [1:0] MA_R15   = 2'd2;

  localparam logic [1:0] MB_REG_B = 2'd0;
  localparam logic [1:0] MB_SHIFT = 2'd1;
  localparam logic [1:0] MB_MDR   = 2'd2;
  localparam logic [1:0] MB_CONST = 2'd3;

  localparam logic [2:0] MC_RD  = 3'd0;
  localparam logic [2:0] MC_R14 = 3'd2;
  localparam logic [2:0] MC_R15 = 3'd3;

  // B-address select that routes Rd onto port B so a store can load MDR
  localparam logic [1:0] MJ_RD = 2'd2;

  function automatic logic is_mem_wait(input logic [3:0] s);
    return (s == S_FETCH1) || (s == S_LS_MEM);
  endfunction

endpackage

// File: rtl/ctrl_seq_decode.sv
// Next-state logic for the control sequencer; purely combinational.
`timescale 1ns/1ps
module ctrl_seq_decode
  import ctrl_seq_pkg::*;
(
  input  logic [3:0] state_i,
  input  logic [7:0] ir_hi_i,
  input  logic       cond_true_i,
  input  logic       moc_i,
  input  logic       timeout_i,
  output logic [3:0] state_d_o
);

  // ir_hi_i carries ir[27:20]
  logic [2:0] cls;
  logic       link;
  logic       load;

  assign cls  = ir_hi_i[7:5];
  assign link = ir_hi_i[4];
  assign load = ir_hi_i[0];

  always_comb begin
    state_d_o = S_FETCH0;
    case (state_i)
      S_RST:     state_d_o = S_FETCH0;
      S_FETCH0:  state_d_o = S_FETCH1;
      S_FETCH1: begin
        if (moc_i)          state_d_o = S_FETCH2;
        else if (timeout_i) state_d_o = S_FETCH0;
        else                state_d_o = S_FETCH1;
      end
      S_FETCH2:  state_d_o = S_DECODE;
      S_DECODE: begin
        if (!cond_true_i)         state_d_o = S_FETCH0;
        else if (cls[2:1] == 2'b00) state_d_o = S_DP;
        else if (cls[2:1] == 2'b01) state_d_o = S_LS_ADDR;
        else if (cls == 3'b101)     state_d_o = link ? S_BR_LINK : S_BR;
        else                        state_d_o = S_FETCH0;
      end
      S_DP:      state_d_o = S_FETCH0;
      S_LS_ADDR: state_d_o = S_LS_MEM;
      S_LS_MEM: begin
        if (moc_i)          state_d_o = load ? S_LDR_WB : S_FETCH0;
        else if (timeout_i) state_d_o = S_FETCH0;
        else                state_d_o = S_LS_MEM;
      end
      S_LDR_WB:  state_d_o = S_FETCH0;
      S_BR_LINK: state_d_o = S_BR;
      S_BR:      state_d_o = S_FETCH0;
      default:   state_d_o = S_FETCH0;
    endcase
  end

endmodule

// File: rtl/ctrl_sequencer.sv
// Hardwired Moore control sequencer driving the single-bus datapath selects.
// Optional memory-handshake timeout: define CTRL_SEQ_MOC_TIMEOUT_EN.
`timescale 1ns/1ps
module ctrl_sequencer
  import ctrl_seq_pkg::*;
#(
  parameter int MOC_TIMEOUT = 16
)(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] ir,
  input  logic        cond_true,
  input  logic        moc,
  output logic [1:0]  ma,
  output logic [1:0]  mb,
  output logic [2:0]  mc,
  output logic        md,
  output logic [4:0]  op,
  output logic        me,
  output logic [1:0]  mf,
  output logic        mg,
  output logic        mh,
  output logic [1:0]  mj,
  output logic        rf_ld,
  output logic        ir_ld,
  output logic        mar_ld,
  output logic        mdr_ld,
  output logic        fr_ld,
  output logic        mov,
  output logic        rw,
  output logic        mem_err,
  output logic [3:0]  state
);

  logic [3:0] state_q;
  logic [3:0] state_d;
  logic       timeout;
  logic       unused_ir;

  assign unused_ir = ^{ir[31:28], ir[19:0]};

  ctrl_seq_decode u_decode (
    .state_i     (state_q),
    .ir_hi_i     (ir[27:20]),
    .cond_true_i (cond_true),
    .moc_i       (moc),
    .timeout_i   (timeout),
    .state_d_o   (state_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_RST;
    else        state_q <= state_d;
  end

  assign state = state_q;

`ifdef CTRL_SEQ_MOC_TIMEOUT_EN
  localparam int CNT_W = (MOC_TIMEOUT > 2) ? $clog2(MOC_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MOC_TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q;

  // Any state change clears the count, so it restarts on every wait entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    cnt_q <= '0;
    else if (state_d != state_q)   cnt_q <= '0;
    else if (is_mem_wait(state_q)) cnt_q <= cnt_q + CNT_W'(1);
  end

  assign timeout = is_mem_wait(state_q) && (cnt_q == CNT_LAST);
  assign mem_err = timeout && !moc;
`else
  assign timeout = 1'b0;
  assign mem_err = 1'b0;
`endif

  always_comb begin
    ma     = '0;
    mb     = '0;
    mc     = '0;
    md     = 1'b0;
    op     = '0;
    me     = 1'b0;
    mf     = '0;
    mg     = 1'b0;
    mh     = 1'b0;
    mj     = '0;
    rf_ld  = 1'b0;
    ir_ld  = 1'b0;
    mar_ld = 1'b0;
    mdr_ld = 1'b0;
    fr_ld  = 1'b0;
    mov    = 1'b0;
    rw     = 1'b0;
    case (state_q)
      S_FETCH0: begin
        ma = MA_R15; md = 1'b1; op = OP_PASS_A; mar_ld = 1'b1;
      end
      S_FETCH1: begin
        mov = 1'b1; rw = 1'b1;
      end
      S_FETCH2: begin
        ir_ld = 1'b1; ma = MA_R15; mb = MB_CONST; op = OP_ADD;
        mc = MC_R15; rf_ld = 1'b1;
      end
      S_DP: begin
        // Compare/test ops only update flags
        ma = MA_RN; mb = MB_SHIFT; mc = MC_RD; md = 1'b0;
        rf_ld = (ir[24:23] != 2'b10);
        fr_ld = ir[20];
      end
      S_LS_ADDR: begin
        ma = MA_RN; mb = MB_SHIFT; md = 1'b1; mar_ld = 1'b1;
        op = ir[23] ? OP_ADD : OP_SUB;
        if (!ir[20]) begin
          mj = MJ_RD; me = 1'b1; mdr_ld = 1'b1;
        end
      end
      S_LS_MEM: begin
        mov = 1'b1; rw = ir[20]; mdr_ld = ir[20];
      end
      S_LDR_WB: begin
        mb = MB_MDR; md = 1'b1; op = OP_PASS_B; mc = MC_RD; rf_ld = 1'b1;
      end
      S_BR_LINK: begin
        ma = MA_R15; md = 1'b1; op = OP_PASS_A; mc = MC_R14; rf_ld = 1'b1;
      end
      S_BR: begin
        ma = MA_R15; mb = MB_SHIFT; op = OP_ADD; mc = MC_R15; rf_ld = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Self-checking bench for ctrl_sequencer: vector table, corner sequences,
// randomized instructions against a cycle/strobe-count reference model.
`timescale 1ns/1ps
module tb_ctrl_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] ir;
  logic        cond_true;
  logic        moc;
  logic [1:0]  ma, mb, mf, mj;
  logic [2:0]  mc;
  logic        md, me, mg, mh;
  logic [4:0]  op;
  logic        rf_ld, ir_ld, mar_ld, mdr_ld, fr_ld, mov, rw, mem_err;
  logic [3:0]  state;

  always #5 clk = ~clk;

  ctrl_sequencer dut (
    .clk(clk), .rst_n(rst_n), .ir(ir), .cond_true(cond_true), .moc(moc),
    .ma(ma), .mb(mb), .mc(mc), .md(md), .op(op), .me(me), .mf(mf), .mg(mg),
    .mh(mh), .mj(mj), .rf_ld(rf_ld), .ir_ld(ir_ld), .mar_ld(mar_ld),
    .mdr_ld(mdr_ld), .fr_ld(fr_ld), .mov(mov), .rw(rw), .mem_err(mem_err),
    .state(state)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
  endtask

  // Reset, then run a zero-wait fetch up to DECODE
  task automatic fetch_to_decode(input logic [31:0] i, input logic c);
    ir = i; cond_true = c; moc = 1'b1;
    do_reset();
    step(); step(); step(); step();
  endtask

  typedef struct {
    logic [31:0] ir;
    logic        cond;
    logic [3:0]  st;
    logic [1:0]  ma;
    logic [1:0]  mb;
    logic [2:0]  mc;
    logic        md;
    logic [4:0]  op;
    logic        rf_ld;
    logic        fr_ld;
    logic        mar_ld;
    logic        mdr_ld;
    logic        me;
    logic [1:0]  mj;
  } vec_t;

  vec_t vecs[10];

  function automatic logic [31:0] out_bundle();
    return {12'd0, ma, mb, mc, md, op, rf_ld, fr_ld, mar_ld, mdr_ld, me, mj};
  endfunction

  function automatic logic [31:0] exp_bundle(input vec_t v);
    return {12'd0, v.ma, v.mb, v.mc, v.md, v.op, v.rf_ld, v.fr_ld, v.mar_ld, v.mdr_ld, v.me, v.mj};
  endfunction

  // Random-phase scratch
  logic [31:0] r_ir;
  logic        r_cond;
  int          fw, mw, wcnt, cyc, cnt_rf, cnt_fr, cnt_mov, cnt_mar, cnt_err;
  int          e_cyc, e_rf, e_fr, e_mov, e_mar;
  logic [3:0]  prev_st;
  int          movc, waitn, errs;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    //                ir            c  st  ma mb mc md op   rf fr mar mdr me mj
    vecs[0] = '{32'hE0812003, 1'b1, 4'd5,  2'd0, 2'd1, 3'd0, 1'b0, 5'd0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
    vecs[1] = '{32'hE1530004, 1'b1, 4'd5,  2'd0, 2'd1, 3'd0, 1'b0, 5'd0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0};
    vecs[2] = '{32'hE0912003, 1'b1, 4'd5,  2'd0, 2'd1, 3'd0, 1'b0, 5'd0,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0};
    vecs[3] = '{32'hE5912004, 1'b1, 4'd6,  2'd0, 2'd1, 3'd0, 1'b1, 5'd4,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0};
    vecs[4] = '{32'hE5012004, 1'b1, 4'd6,  2'd0, 2'd1, 3'd0, 1'b1, 5'd2,  1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'd2};
    vecs[5] = '{32'hEB000010, 1'b1, 4'd9,  2'd2, 2'd0, 3'd2, 1'b1, 5'd16, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
    vecs[6] = '{32'hEA000010, 1'b1, 4'd10, 2'd2, 2'd1, 3'd3, 1'b0, 5'd4,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
    vecs[7] = '{32'hE0812003, 1'b0, 4'd1,  2'd2, 2'd0, 3'd0, 1'b1, 5'd16, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0};
    vecs[8] = '{32'hEF000000, 1'b1, 4'd1,  2'd2, 2'd0, 3'd0, 1'b1, 5'd16, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0};
    vecs[9] = '{32'hEC000000, 1'b1, 4'd1,  2'd2, 2'd0, 3'd0, 1'b1, 5'd16, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0};

    // Reset state and the fetch walk
    ir = 32'hE0812003; cond_true = 1'b1; moc = 1'b1; rst_n = 1'b0;
    #1;
    check("reset_state", state, 4'd0);
    check("reset_outputs", {4'd0, ma, mb, mc, md, op, me, mf, mg, mh, mj,
                            rf_ld, ir_ld, mar_ld, mdr_ld, fr_ld, mov, rw, mem_err}, 32'd0);
    #2; rst_n = 1'b1;
    step();
    check("fetch0_state", state, 4'd1);
    check("fetch0_ma_marld", {ma, mar_ld, md, op}, {2'd2, 1'b1, 1'b1, 5'd16});
    step();
    check("fetch1_state", state, 4'd2);
    check("fetch1_mov_rw", {mov, rw}, 2'b11);
    step();
    check("fetch2_state", state, 4'd3);
    check("fetch2_outs", {ir_ld, rf_ld, ma, mb, mc, op}, {1'b1, 1'b1, 2'd2, 2'd3, 3'd3, 5'd4});
    step();
    check("decode_state", state, 4'd4);
    check("decode_no_strobes", {rf_ld, ir_ld, mar_ld, mdr_ld, fr_ld, mov}, 6'd0);
    step();
    check("add_dp_state", state, 4'd5);
    step();
    check("add_back_fetch0", state, 4'd1);

    // Vector table: first state after DECODE and its outputs
    for (int i = 0; i < 10; i++) begin
      fetch_to_decode(vecs[i].ir, vecs[i].cond);
      step();
      check($sformatf("vec%0d_state", i), state, vecs[i].st);
      check($sformatf("vec%0d_outs", i), out_bundle(), exp_bundle(vecs[i]));
    end

    // LDR with memory completion delayed three cycles
    fetch_to_decode(32'hE5912004, 1'b1);
    moc = 1'b0;
    step();
    check("ldr_lsaddr_op", {state, op}, {4'd6, 5'd4});
    step();
    movc = 0;
    for (int k = 0; k < 20 && state == 4'd7; k++) begin
      if (mov) movc++;
      if (movc == 4) moc = 1'b1;
      step();
    end
    moc = 1'b0;
    check("ldr_mov_cycles", movc, 4);
    check("ldr_wb_state_mb", {state, mb, op, rf_ld}, {4'd8, 2'd2, 5'd13, 1'b1});
    step();
    check("ldr_done_fetch0", {state, mov}, {4'd1, 1'b0});

    // Branch with link walks BR_LINK -> BR -> FETCH0
    fetch_to_decode(32'hEB000010, 1'b1);
    step();
    check("bl_link_mc", {state, mc}, {4'd9, 3'd2});
    step();
    check("bl_br_mc", {state, mc}, {4'd10, 3'd3});
    step();
    check("bl_back_fetch0", state, 4'd1);

    // Stuck memory in FETCH1
    moc = 1'b0;
    do_reset();
    step(); step();
    waitn = 0; errs = 0;
`ifdef CTRL_SEQ_MOC_TIMEOUT_EN
    for (int k = 1; k <= 40; k++) begin
      if (mem_err) begin
        waitn = k;
        errs++;
        break;
      end
      step();
    end
    check("timeout_wait_cycle", waitn, 16);
    step();
    check("timeout_state_after", {state, mem_err}, {4'd1, 1'b0});
`else
    for (int k = 1; k <= 40; k++) begin
      if (mem_err) errs++;
      step();
    end
    check("no_timeout_mem_err", errs, 0);
    check("no_timeout_still_waiting", {state, mov}, {4'd2, 1'b1});
`endif

    // Asynchronous reset in the middle of the data handshake
    fetch_to_decode(32'hE5912004, 1'b1);
    moc = 1'b0;
    step(); step();
    check("lsmem_before_reset", {state, mov}, {4'd7, 1'b1});
    #2; rst_n = 1'b0;
    #1;
    check("async_reset_mov", {state, mov}, {4'd0, 1'b0});
    #1; rst_n = 1'b1;

    // Randomized instructions against cycle and strobe-count model
    moc = 1'b1;
    do_reset();
    step();
    for (int t = 0; t < 60; t++) begin
      r_ir = $urandom();
      r_ir[27:25] = 3'($urandom_range(0, 7));
      r_cond = ($urandom_range(0, 3) != 0);
      fw = $urandom_range(0, 3);
      mw = $urandom_range(0, 3);
      ir = r_ir; cond_true = r_cond;

      e_cyc = 4 + fw; e_rf = 1; e_fr = 0; e_mov = fw + 1; e_mar = 1;
      if (r_cond) begin
        if (r_ir[27:26] == 2'b00) begin
          e_cyc += 1;
          e_rf  += (r_ir[24:23] != 2'b10) ? 1 : 0;
          e_fr   = r_ir[20] ? 1 : 0;
        end else if (r_ir[27:26] == 2'b01) begin
          e_cyc += 2 + mw + (r_ir[20] ? 1 : 0);
          e_rf  += r_ir[20] ? 1 : 0;
          e_mov += mw + 1;
          e_mar += 1;
        end else if (r_ir[27:25] == 3'b101) begin
          e_cyc += r_ir[24] ? 2 : 1;
          e_rf  += r_ir[24] ? 2 : 1;
        end
      end

      cyc = 0; cnt_rf = 0; cnt_fr = 0; cnt_mov = 0; cnt_mar = 0; cnt_err = 0;
      prev_st = 4'hF; wcnt = 0;
      do begin
        cyc++;
        cnt_rf  += rf_ld  ? 1 : 0;
        cnt_fr  += fr_ld  ? 1 : 0;
        cnt_mov += mov    ? 1 : 0;
        cnt_mar += mar_ld ? 1 : 0;
        cnt_err += mem_err ? 1 : 0;
        if (state == 4'd2 || state == 4'd7) begin
          if (state != prev_st) wcnt = 0;
          moc = (wcnt >= ((state == 4'd2) ? fw : mw));
          wcnt++;
        end else begin
          moc = 1'($urandom_range(0, 1));
        end
        prev_st = state;
        step();
      end while (state != 4'd1 && cyc < 40);

      check($sformatf("rnd%0d_cycles", t), cyc, e_cyc);
      check($sformatf("rnd%0d_rf_ld", t), cnt_rf, e_rf);
      check($sformatf("rnd%0d_fr_ld", t), cnt_fr, e_fr);
      check($sformatf("rnd%0d_mov", t), cnt_mov, e_mov);
      check($sformatf("rnd%0d_mar_ld", t), cnt_mar, e_mar);
      check($sformatf("rnd%0d_mem_err", t), cnt_err, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
